stage_memory: RTL and testbench

Memory-access stage of the RISC-E pipeline, the consumer of the execute stage's `alu_res`, `reg_write_back` and `dmem_read_write` outputs. It turns loads and stores into requests on a word-wide data-memory port with a req/ack handshake. It aligns and sign-extends load data, builds byte strobes for stores, and registers one write-back record per instruction. Non-memory instructions pass through with one cycle of latency; memory instructions hold the stage busy until the memory acknowledges or times out.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/stage_memory_if.sv | 25 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/stage_memory.sv | 184 ++++++++++++++++++
 tb/tb_stage_memory.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-E definitions: opcodes, load/store width
// encodings, memory-stage FSM states and alignment check.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE,
      REQ
   } mem_state_t;

   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic half;
      half = (f3 == F3_H) || (f3 == F3_HU);
      return (half && a[0]) || ((f3 == F3_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/stage_memory_if.sv
// Data-memory port: req/ack handshake, word address,
// write data/strobes out, read data in (valid with ack).
interface stage_memory_if;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr,
      output dmem_wdata, dmem_wstrb,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr,
      input  dmem_wdata, dmem_wstrb,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational load/store alignment: store strobes and
// replicated data; load byte/half select and extension.
// Ports: funct3, a (addr[1:0]), is_store, rs2, rdata in;
// wstrb, wdata, ldata out.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  a,
   input  logic        is_store,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{a, 3'b000} +: 8];
      // Halfwords only look at a[1]
      half_sel = a[1] ? rdata[31:16] : rdata[15:0];
      ldata = rdata;
      unique case (funct3)
         F3_B:  ldata = {{24{byte_sel[7]}}, byte_sel};
         F3_H:  ldata = {{16{half_sel[15]}}, half_sel};
         F3_BU: ldata = {24'h0, byte_sel};
         F3_HU: ldata = {16'h0, half_sel};
         default: ldata = rdata;
      endcase
   end

   always_comb begin
      wstrb = 4'b0000;
      wdata = rs2;
      if (is_store) begin
         unique case (funct3)
            F3_B: begin
               wstrb = 4'b0001 << a;
               wdata = {4{rs2[7:0]}};
            end
            F3_H: begin
               wstrb = 4'b0011 << {a[1], 1'b0};
               wdata = {2{rs2[15:0]}};
            end
            default: begin
               wstrb = 4'b1111;
               wdata = rs2;
            end
         endcase
      end
   end

endmodule

// File: rtl/stage_memory.sv
// Memory-access stage: issues loads/stores on the dmem port,
// aligns results and registers one write-back per instruction.
// Ports: clk, rst_n; execute inputs (in_valid/in_ready, pc,
// opcode, funct3, alu_res, rs2, addr_rd, reg_write_back,
// dmem_read_write); dmem (stage_memory_if.master); write-back
// (wb_valid, wb_en, wb_rd, wb_data); bus_err pulse.
// Option MEM_MISALIGN_TRAP_EN adds the misalign pulse port.
module stage_memory
   import riscv_pkg::*;
#(
   parameter int unsigned DMEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] pc,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_res,
   input  logic [31:0] rs2,
   input  logic [4:0]  addr_rd,
   input  logic        reg_write_back,
   input  logic        dmem_read_write,
   stage_memory_if.master dmem,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic        bus_err
);

   // Counter value of the last REQ cycle allowed to wait
   localparam logic [7:0] TMO_LAST = 8'(DMEM_TIMEOUT - 1);

   mem_state_t  state, state_nx;
   logic [7:0]  cnt;
   logic [31:0] lat_a, lat_rs2;
   logic [2:0]  lat_f3;
   logic [4:0]  lat_rd;
   logic        lat_st, lat_wbe;

   logic        accept, is_mem, is_link, mis, timeout, req;
   logic [31:0] ldata, wdata;
   logic [3:0]  wstrb;

   logic        wb_valid_nx, wb_en_nx, err_nx;
   logic [4:0]  wb_rd_nx;
   logic [31:0] wb_data_nx;

   assign in_ready = (state == IDLE);
   assign req      = (state == REQ);
   assign accept   = in_valid && in_ready;
   assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
   assign is_link  = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign timeout  = (cnt == TMO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = is_mem && misaligned(funct3, alu_res[1:0]);
`else
   assign mis = 1'b0;
`endif

   lsu_align u_align (
      .funct3   (lat_f3),
      .a        (lat_a[1:0]),
      .is_store (lat_st),
      .rs2      (lat_rs2),
      .rdata    (dmem.dmem_rdata),
      .wstrb    (wstrb),
      .wdata    (wdata),
      .ldata    (ldata)
   );

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = req && lat_st;
   assign dmem.dmem_addr  = {lat_a[31:2], 2'b00};
   assign dmem.dmem_wdata = wdata;
   assign dmem.dmem_wstrb = req ? wstrb : 4'b0000;

   always_comb begin
      state_nx    = state;
      wb_valid_nx = 1'b0;
      wb_en_nx    = 1'b0;
      wb_rd_nx    = wb_rd;
      wb_data_nx  = wb_data;
      err_nx      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (is_mem && !mis) begin
                  state_nx = REQ;
               end else begin
                  wb_valid_nx = 1'b1;
                  wb_rd_nx    = addr_rd;
                  if (mis) begin
                     wb_data_nx = 32'h0;
                  end else begin
                     wb_en_nx   = reg_write_back;
                     wb_data_nx = is_link ? pc + 32'd4 : alu_res;
                  end
               end
            end
         end
         REQ: begin
            // Ack wins over a coincident timeout
            if (dmem.dmem_ack) begin
               state_nx    = IDLE;
               wb_valid_nx = 1'b1;
               wb_rd_nx    = lat_rd;
               wb_en_nx    = lat_st ? 1'b0 : lat_wbe;
               wb_data_nx  = lat_st ? 32'h0 : ldata;
            end else if (timeout) begin
               state_nx    = IDLE;
               wb_valid_nx = 1'b1;
               wb_rd_nx    = lat_rd;
               wb_data_nx  = 32'h0;
               err_nx      = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'h0;
      end else begin
         state <= state_nx;
         if (accept)
            cnt <= 8'h0;
         else if (req && !dmem.dmem_ack)
            cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_a   <= 32'h0;
         lat_rs2 <= 32'h0;
         lat_f3  <= 3'h0;
         lat_rd  <= 5'h0;
         lat_st  <= 1'b0;
         lat_wbe <= 1'b0;
      end else if (accept && is_mem) begin
         lat_a   <= alu_res;
         lat_rs2 <= rs2;
         lat_f3  <= funct3;
         lat_rd  <= addr_rd;
         lat_st  <= dmem_read_write;
         lat_wbe <= reg_write_back;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_en    <= 1'b0;
         wb_rd    <= 5'h0;
         wb_data  <= 32'h0;
         bus_err  <= 1'b0;
      end else begin
         wb_valid <= wb_valid_nx;
         wb_en    <= wb_en_nx;
         wb_rd    <= wb_rd_nx;
         wb_data  <= wb_data_nx;
         bus_err  <= err_nx;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         misalign <= 1'b0;
      else
         misalign <= accept && is_mem && mis;
   end
`endif

endmodule

// File: tb/tb_stage_memory.sv
// Directed self-checking bench for stage_memory
// (DMEM_TIMEOUT=4); misalign section under MEM_MISALIGN_TRAP_EN.
module tb_stage_memory;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] pc, alu_res, rs2;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  addr_rd;
   logic        reg_write_back, dmem_read_write;
   logic        wb_valid, wb_en, bus_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int nchk = 0;
   int nfail = 0;
   int n;

   stage_memory_if bus();

   stage_memory #(.DMEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .pc              (pc),
      .opcode          (opcode),
      .funct3          (funct3),
      .alu_res         (alu_res),
      .rs2             (rs2),
      .addr_rd         (addr_rd),
      .reg_write_back  (reg_write_back),
      .dmem_read_write (dmem_read_write),
      .dmem            (bus),
      .wb_valid        (wb_valid),
      .wb_en           (wb_en),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign        (misalign),
`endif
      .bus_err         (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setin(input logic [6:0]  op,
                        input logic [2:0]  f3,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [4:0]  rd,
                        input logic        wbe,
                        input logic        st,
                        input logic [31:0] p);
      opcode = op; funct3 = f3; alu_res = a; rs2 = d;
      addr_rd = rd; reg_write_back = wbe;
      dmem_read_write = st; pc = p; in_valid = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0;
      pc = 0; opcode = 0; funct3 = 0; alu_res = 0; rs2 = 0;
      addr_rd = 0; reg_write_back = 0; dmem_read_write = 0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_req", 32'(bus.dmem_req), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      rst_n = 1'b1;
      step();

      // ADDI then JAL back to back
      setin(7'b0010011, 3'd0, 32'h1234, 0, 5'd5, 1, 0, 32'h0);
      step();
      chk("addi_valid", 32'(wb_valid), 32'd1);
      chk("addi_en", 32'(wb_en), 32'd1);
      chk("addi_rd", 32'(wb_rd), 32'd5);
      chk("addi_data", wb_data, 32'h1234);
      chk("addi_req", 32'(bus.dmem_req), 32'd0);
      chk("addi_ready", 32'(in_ready), 32'd1);
      setin(OP_JAL, 3'd0, 32'h0, 0, 5'd1, 1, 0, 32'h100);
      step();
      in_valid = 1'b0;
      chk("jal_valid", 32'(wb_valid), 32'd1);
      chk("jal_rd", 32'(wb_rd), 32'd1);
      chk("jal_data", wb_data, 32'h104);
      step();
      chk("idle_valid", 32'(wb_valid), 32'd0);

      // LB 0x1003, ack after 2 wait cycles
      setin(OP_LOAD, F3_B, 32'h1003, 0, 5'd7, 1, 0, 32'h0);
      step();
      in_valid = 1'b0;
      chk("lb_req", 32'(bus.dmem_req), 32'd1);
      chk("lb_addr", bus.dmem_addr, 32'h1000);
      chk("lb_we", 32'(bus.dmem_we), 32'd0);
      chk("lb_strb", 32'(bus.dmem_wstrb), 32'd0);
      chk("lb_ready", 32'(in_ready), 32'd0);
      step();
      chk("lb_wait_valid", 32'(wb_valid), 32'd0);
      chk("lb_wait_addr", bus.dmem_addr, 32'h1000);
      step();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80FFFFFF;
      step();
      bus.dmem_ack = 1'b0;
      chk("lb_valid", 32'(wb_valid), 32'd1);
      chk("lb_data", wb_data, 32'hFFFFFF80);
      chk("lb_en", 32'(wb_en), 32'd1);
      chk("lb_rd", 32'(wb_rd), 32'd7);
      chk("lb_req_done", 32'(bus.dmem_req), 32'd0);
      chk("lb_ready_done", 32'(in_ready), 32'd1);

      // LBU same access, ack in first REQ cycle
      setin(OP_LOAD, F3_BU, 32'h1003, 0, 5'd7, 1, 0, 32'h0);
      step();
      in_valid = 1'b0;
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
      chk("lbu_data", wb_data, 32'h00000080);
      chk("lbu_valid", 32'(wb_valid), 32'd1);

      // LH / LHU upper half
      setin(OP_LOAD, F3_H, 32'h1002, 0, 5'd8, 1, 0, 32'h0);
      step();
      in_valid = 1'b0;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80011234;
      step();
      chk("lh_data", wb_data, 32'hFFFF8001);
      setin(OP_LOAD, F3_HU, 32'h1002, 0, 5'd8, 1, 0, 32'h0);
      bus.dmem_ack = 1'b0;
      step();
      in_valid = 1'b0;
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
      chk("lhu_data", wb_data, 32'h00008001);

      // SH 0x2002
      setin(OP_STORE, F3_H, 32'h2002, 32'hDEADBEEF, 5'd3, 0, 1, 0);
      step();
      in_valid = 1'b0;
      chk("sh_we", 32'(bus.dmem_we), 32'd1);
      chk("sh_strb", 32'(bus.dmem_wstrb), 32'hC);
      chk("sh_wdata", bus.dmem_wdata, 32'hBEEFBEEF);
      chk("sh_addr", bus.dmem_addr, 32'h2000);
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
      chk("sh_valid", 32'(wb_valid), 32'd1);
      chk("sh_en", 32'(wb_en), 32'd0);
      chk("sh_data", wb_data, 32'h0);

      // SB 0x1001
      setin(OP_STORE, F3_B, 32'h1001, 32'h000000A5, 5'd0, 0, 1, 0);
      step();
      in_valid = 1'b0;
      chk("sb_strb", 32'(bus.dmem_wstrb), 32'h2);
      chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;

      // SW
      setin(OP_STORE, F3_W, 32'h4008, 32'h12345678, 5'd0, 0, 1, 0);
      step();
      in_valid = 1'b0;
      chk("sw_strb", 32'(bus.dmem_wstrb), 32'hF);
      chk("sw_wdata", bus.dmem_wdata, 32'h12345678);
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;

      // Ack outside REQ is ignored
      bus.dmem_ack = 1'b1;
      step();
      step();
      bus.dmem_ack = 1'b0;
      chk("stray_ack_valid", 32'(wb_valid), 32'd0);
      chk("stray_ack_ready", 32'(in_ready), 32'd1);

      // Timeout with no ack
      setin(OP_LOAD, F3_W, 32'h10, 0, 5'd9, 1, 0, 0);
      step();
      in_valid = 1'b0;
      n = 0;
      while (bus.dmem_req && n < 20) begin
         n++;
         step();
      end
      chk("tmo_req_cycles", 32'(n), 32'd4);
      chk("tmo_bus_err", 32'(bus_err), 32'd1);
      chk("tmo_valid", 32'(wb_valid), 32'd1);
      chk("tmo_en", 32'(wb_en), 32'd0);
      chk("tmo_ready", 32'(in_ready), 32'd1);
      step();
      chk("tmo_err_pulse", 32'(bus_err), 32'd0);

      // Ack in the timeout cycle completes normally
      setin(OP_LOAD, F3_W, 32'h20, 0, 5'd10, 1, 0, 0);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("tmo_ack_req", 32'(bus.dmem_req), 32'd1);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h11223344;
      step();
      bus.dmem_ack = 1'b0;
      chk("tmo_ack_err", 32'(bus_err), 32'd0);
      chk("tmo_ack_data", wb_data, 32'h11223344);
      chk("tmo_ack_en", 32'(wb_en), 32'd1);

      // Reset mid-REQ
      setin(OP_LOAD, F3_W, 32'h30, 0, 5'd11, 1, 0, 0);
      step();
      in_valid = 1'b0;
      chk("rst_mid_req_before", 32'(bus.dmem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 32'(bus.dmem_req), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_mid_valid", 32'(wb_valid), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
      setin(OP_LOAD, F3_W, 32'h3001, 0, 5'd12, 1, 0, 0);
      step();
      in_valid = 1'b0;
      chk("mis_req", 32'(bus.dmem_req), 32'd0);
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_valid", 32'(wb_valid), 32'd1);
      chk("mis_en", 32'(wb_en), 32'd0);
      step();
      chk("mis_pulse_end", 32'(misalign), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
